slc3_mmio_bridge: RTL
=====================

Name: slc3_mmio_bridge

Overview:
Memory-side stage directly downstream of the SLC-3 control FSM and datapath. It consumes mem_ena, mem_wr_ena, MAR and MDR, and decodes each access to on-chip BRAM or to memory-mapped I/O: the switches on read, the hex display on write. It returns read data aligned to the FSM's fixed 3-cycle memory window (states 33_1..33_3, 25_1..25_3, 16_1..16_3). It also owns the hex display register and drives the 4-digit multiplexed 7-segment display.

Parameters:
ADDR_W, 16, BRAM address width; BRAM covers addresses below 2**ADDR_W, except IO_ADDR.
IO_ADDR, 16'hFFFF, MMIO address: read returns switches, write loads the hex register.
SCAN_BITS, 16, width of the display scan counter; bits [SCAN_BITS-1:SCAN_BITS-2] select the digit.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_ena  in  1  memory window active (FSM holds it high for 3 consecutive cycles)
mem_wr_ena  in  1  window is a write
mar  in  16  access address (stable for the whole window)
mdr  in  16  write data
mem_rdata  out  16  read data to the MDR input mux
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write strobe
bram_addr  out  ADDR_W  BRAM address, equal to mar[ADDR_W-1:0]
bram_wdata  out  16  equal to mdr
bram_rdata  in  16  BRAM read data (2-cycle latency: synchronous read plus output register)
sw_i  in  16  asynchronous slide switches
hex_grid  out  4  digit enables, active-low one-hot
hex_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)

Behaviour:
- Decode (combinational on mar):
  - is_io = (mar == IO_ADDR).
  - is_bram = !is_io && mar < 2**ADDR_W.
  - Otherwise the access is unmapped.
- Window start: start = mem_ena & ~ena_d1, where ena_d1 is mem_ena registered.
  - A new window requires mem_ena low for at least one cycle; back-to-back high cycles are one window.
- Writes (mem_ena & mem_wr_ena):
  - bram_we pulses high only on the start cycle, and only when is_bram.
  - If is_io, hex_value <= mdr at the end of the start cycle.
  - Unmapped writes are dropped.
  - Repeat cycles of the window never re-write.
- bram_en = mem_ena & is_bram, for both reads and writes.
- Reads: the source select {NONE, BRAM, IO} is piped through two registers (sel_d1, sel_d2), sampled every cycle.
  - sel = NONE when mem_ena is low, when mem_wr_ena is high, or when the address is unmapped.
  - sw_sync (2-flop synchronizer on sw_i) is also piped two stages (io_d1, io_d2).
  - mem_rdata = bram_rdata when sel_d2 = BRAM; io_d2 when sel_d2 = IO; 16'h0000 when sel_d2 = NONE.
  - Read data is valid from cycle t+2 (t = start cycle) and held while the window continues. This is the FSM's third window cycle, where ld_mdr captures it.
- Display:
  - scan_cnt increments every cycle and wraps.
  - digit = scan_cnt[SCAN_BITS-1:SCAN_BITS-2]; digit 0 shows hex_value[3:0] with hex_grid = 4'b1110, and so on up to digit 3 showing [15:12].
  - hex_seg is the registered output of a nibble-to-segment decode, so it is one cycle behind the digit select.
  - hex_grid is registered in the same stage so the two stay aligned.
- Reset (also mid-window):
  - hex_value = 0, scan_cnt = 0, sync/pipe registers = 0, sel_d1/sel_d2 = NONE, ena_d1 = 0.
  - Therefore mem_rdata = 0, hex_grid = 4'b1111, hex_seg = 8'hFF, bram_we = 0.
  - A window interrupted by reset issues no write.
  - If mem_ena is still high when reset releases, the next cycle counts as a new start.
- Simultaneous events:
  - A display scan wrap concurrent with a hex write shows the new value from the following cycle.
  - A switch change during a read window is reflected only if it reaches io_d2 by t+2; no further guarantee.

Decomposition:
- Package slc3_pkg: typedef enum logic [1:0] mem_src_t {SRC_NONE, SRC_BRAM, SRC_IO}; constant IO_ADDR_DEFAULT = 16'hFFFF; 16-bit word typedef.
- One sub-module: hex_seg_decoder (4-bit nibble to 7-segment pattern, active-low, combinational), instantiated once in front of the segment register.

Test Plan:
- Reset, then idle 4 cycles -> mem_rdata = 0000, hex_grid = 1111 until the first scan step, bram_we never asserted.
- Write window, mar = 0x0010, mdr = 0xBEEF, mem_ena high 3 cycles -> bram_we high exactly 1 cycle (the start cycle) with addr 0x0010. A following read window at 0x0010 gives mem_rdata = 0xBEEF at t+2 (BRAM model with 2-cycle latency).
- Write window, mar = 0xFFFF, mdr = 0x1234 -> bram_we stays 0, hex_value = 0x1234. Across one scan period, hex_seg shows the patterns for 4, 3, 2, 1 on grids 1110, 1101, 1011, 0111.
- sw_i = 0xA5A5 held, then read window at 0xFFFF -> mem_rdata = 0xA5A5 at t+2 and t+3; bram_en = 0 throughout.
- ADDR_W = 12, read at 0x2000 -> mem_rdata = 0x0000, bram_en = 0. Write to 0x2000 -> no BRAM write, hex unchanged.
- Reset asserted in the second cycle of an I/O write window with mdr = 0x5555 after the start cycle's write has completed -> hex_value = 0 after reset. Reset asserted in the start cycle itself -> no write occurs.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared types for the SLC-3 memory-side bridge: read-source select and word type.
package slc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BRAM = 2'd1,
        SRC_IO   = 2'd2
    } mem_src_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_mmio_bridge_if.sv
// FSM-to-memory bus: the control FSM is master, the bridge is slave.
interface slc3_mmio_bridge_if;
    import slc3_pkg::*;

    logic  mem_ena;
    logic  mem_wr_ena;
    word_t mar;
    word_t mdr;
    word_t mem_rdata;

    modport master (
        output mem_ena, mem_wr_ena, mar, mdr,
        input  mem_rdata
    );

    modport slave (
        input  mem_ena, mem_wr_ena, mar, mdr,
        output mem_rdata
    );

endinterface

// File: rtl/hex_seg_decoder.sv
// Nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-low (0 lights a segment).
module hex_seg_decoder (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/slc3_mmio_bridge.sv
// Decodes FSM memory windows to BRAM or MMIO (switches / hex register), aligns read
// data to the third window cycle, and scans the hex register onto a 4-digit display.
module slc3_mmio_bridge
    import slc3_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT,
    parameter int          SCAN_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    slc3_mmio_bridge_if.slave mem,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output word_t             bram_wdata,
    input  word_t             bram_rdata,
    input  word_t             sw_i,
    output logic [3:0]        hex_grid,
    output logic [7:0]        hex_seg
);

    logic     is_io, is_bram, in_range, start, wr_start;
    logic     ena_q;
    mem_src_t sel_d, sel_d1_q, sel_d2_q;
    word_t    hex_q, sw_meta_q, sw_sync_q, io_d1_q, io_d2_q;

    logic [SCAN_BITS-1:0] scan_q;
    logic [1:0]           digit;
    logic [3:0]           nibble, grid_d, grid_q;
    logic [6:0]           seg7;
    logic [7:0]           seg_q;

    // Upper address bits must be clear; with a full 16-bit BRAM everything is in range.
    generate
        if (ADDR_W >= 16) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (mem.mar[15:ADDR_W] == '0);
        end
    endgenerate

    assign is_io   = (mem.mar == IO_ADDR);
    assign is_bram = !is_io && in_range;

    // Reset gating keeps a window caught by reset from committing anything.
    assign start    = mem.mem_ena & ~ena_q;
    assign wr_start = start & mem.mem_wr_ena & ~reset;

    assign bram_en    = mem.mem_ena & is_bram;
    assign bram_we    = wr_start & is_bram;
    assign bram_addr  = mem.mar[ADDR_W-1:0];
    assign bram_wdata = mem.mdr;

    always_comb begin
        sel_d = SRC_NONE;
        if (mem.mem_ena && !mem.mem_wr_ena) begin
            if (is_io)        sel_d = SRC_IO;
            else if (is_bram) sel_d = SRC_BRAM;
        end
    end

    always_comb begin
        mem.mem_rdata = 16'h0000;
        case (sel_d2_q)
            SRC_BRAM: mem.mem_rdata = bram_rdata;
            SRC_IO:   mem.mem_rdata = io_d2_q;
            default:  mem.mem_rdata = 16'h0000;
        endcase
    end

    assign digit  = scan_q[SCAN_BITS-1 -: 2];
    assign nibble = hex_q[{digit, 2'b00} +: 4];
    assign grid_d = ~(4'b0001 << digit);

    hex_seg_decoder u_dec (
        .nibble_i (nibble),
        .seg_o    (seg7)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ena_q     <= 1'b0;
            sel_d1_q  <= SRC_NONE;
            sel_d2_q  <= SRC_NONE;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            io_d1_q   <= '0;
            io_d2_q   <= '0;
            hex_q     <= '0;
            scan_q    <= '0;
            grid_q    <= 4'b1111;
            seg_q     <= 8'hFF;
        end else begin
            ena_q     <= mem.mem_ena;
            sel_d1_q  <= sel_d;
            sel_d2_q  <= sel_d1_q;
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            io_d1_q   <= sw_sync_q;
            io_d2_q   <= io_d1_q;
            if (wr_start && is_io)
                hex_q <= mem.mdr;
            scan_q    <= scan_q + 1'b1;
            grid_q    <= grid_d;
            seg_q     <= {1'b1, seg7};
        end
    end

    assign hex_grid = grid_q;
    assign hex_seg  = seg_q;

endmodule
